tagged_register_file: RTL and testbench
=======================================

Name: tagged_register_file

Overview:
- Architectural register file with renaming tags for the out-of-order core. Generalises the single-broadcast file to NUM_REGS registers, ISSUE_WIDTH issue slots and NUM_BCAST common-data-bus channels.
- Adds:
  - hardwired-zero r0
  - same-cycle broadcast bypass to the read ports
  - intra-bundle rename forwarding
  - a flush that drops all pending tags
  - a registered pending-register count
- Sits between decode/issue and the reservation stations. Broadcasts come from the functional-unit result buses.

Parameters:
- DATA_WIDTH, 64, register value width.
- NUM_REGS, 32, architectural registers; power of two, ≥ 2.
- ISSUE_WIDTH, 3, issue slots per cycle; slot 0 is oldest.
- NUM_BCAST, 2, broadcast channels per cycle.
- TAG_WIDTH, 4, reservation-station tag width; TAG_WIDTH ≤ DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  drop all pending tags.
- issue_wr_en_i  in  [ISSUE_WIDTH]x1  slot renames its destination.
- issue_dst_i  in  [ISSUE_WIDTH]x$clog2(NUM_REGS)  destination register.
- issue_tag_i  in  [ISSUE_WIDTH]xTAG_WIDTH  producing station tag.
- bcast_valid_i  in  [NUM_BCAST]x1  result valid.
- bcast_tag_i  in  [NUM_BCAST]xTAG_WIDTH  result tag.
- bcast_value_i  in  [NUM_BCAST]xDATA_WIDTH  result value.
- rd_reg1_i, rd_reg2_i  in  [ISSUE_WIDTH]x$clog2(NUM_REGS)  source registers.
- rd1_virtual_o, rd2_virtual_o  out  [ISSUE_WIDTH]x1  operand is a pending tag.
- rd1_data_o, rd2_data_o  out  [ISSUE_WIDTH]xDATA_WIDTH  value, or tag zero-extended when virtual.
- pending_count_o  out  $clog2(NUM_REGS+1)  number of registers currently virtual.

Behaviour:
- State per register: virtual bit, value[DATA_WIDTH], tag[TAG_WIDTH].
- Reset (async): all values 0, virtual 0, tags 0, pending_count_o 0. Read outputs are combinational from state, so they read 0 / non-virtual during reset.
- r0 is always value 0, non-virtual. Issue writes to r0 are ignored; reads of r0 return 0/non-virtual regardless of bypass or forwarding.
- Read path (combinational, zero latency), per slot j, per operand register r, first match wins:
  - (a) r == 0 → 0, non-virtual.
  - (b) Youngest earlier slot i < j with issue_wr_en_i[i] and issue_dst_i[i] == r → virtual, data = issue_tag_i[i].
  - (c) r virtual and some valid broadcast with tag == stored tag → non-virtual, that value; lowest channel index wins.
  - (d) Stored state.
- Broadcast update (clock edge): each virtual register whose stored tag matches a valid channel's tag becomes non-virtual with that value.
  - Lowest channel wins on duplicate tags; duplicate tags in one cycle are illegal upstream.
  - Non-virtual registers ignore broadcasts, so a stale tag never overwrites.
- Issue update (clock edge): for each enabled slot, set dst virtual with the new tag.
  - Same dst in several slots: highest slot index wins.
  - Issue overrides a broadcast to the same register in the same cycle; the new tag is kept and the broadcast value is discarded.
- Flush (clock edge): all virtual bits cleared, values and tags unchanged. Flush overrides issue and broadcast in the same cycle: both are ignored, and pending_count_o becomes 0.
- pending_count_o: registered population count of virtual bits, updated on the same edge as the state it describes. Never exceeds NUM_REGS-1 because r0 is never virtual.
- Reset asserted mid-cycle clears state immediately and asynchronously. Deassertion is synchronised externally.

Test Plan:
- Reset, then read r5 → data 0, non-virtual, pending_count 0. Issue r0 with tag 3 → r0 stays 0/non-virtual, count stays 0.
- Issue slot0 r4 tag 2; next cycle read r4 → virtual, data 2, count 1. Broadcast tag 2 value 0xDEAD the same cycle as the read → read shows 0xDEAD non-virtual. Next cycle stored value is 0xDEAD, count 0.
- Single bundle, slot0 issues r7 tag 1, slot1 issues r7 tag 5, slot2 reads r7 → slot2 sees virtual tag 5. Next cycle r7 holds tag 5, count 1.
- r9 pending tag 4. Issue r9 tag 6 together with broadcast tag 4 value 0x11 → r9 remains virtual tag 6. A later broadcast of tag 4 leaves r9 virtual.
- r2 pending tag 1, r3 pending tag 2. Channel0 broadcasts tag 1 = 0xA and channel1 broadcasts tag 2 = 0xB in one cycle → r2 = 0xA, r3 = 0xB, count goes 2 → 0.
- Three registers pending; assert flush together with an issue to r10 → all non-virtual with old values, r10 not renamed, count 0. Async reset asserted mid-cycle → outputs zero before the next edge.

Source files
------------

// File: rtl/tagged_register_file.sv
// tagged_register_file
//   Architectural register file with renaming tags for the out-of-order core.
//   Each register holds a value, a reservation-station tag and a virtual bit
//   (set while the register waits for a result broadcast). r0 is hardwired to
//   zero. Reads are combinational and include a same-cycle broadcast bypass and
//   intra-bundle rename forwarding. A flush drops all pending tags.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   flush_i              clear every virtual bit (values/tags kept)
//   issue_wr_en_i/dst/tag per issue slot: rename dst to the producing tag
//   bcast_valid/tag/value per broadcast channel: result on the data bus
//   rd_reg1_i/rd_reg2_i  per issue slot: source register numbers
//   rd1_*/rd2_*          per issue slot: virtual flag and value-or-tag
//   pending_count_o      registered count of virtual registers
module tagged_register_file #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_REGS    = 32,
  parameter int ISSUE_WIDTH = 3,
  parameter int NUM_BCAST   = 2,
  parameter int TAG_WIDTH   = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [ISSUE_WIDTH-1:0]                issue_wr_en_i,
  input  logic [ISSUE_WIDTH-1:0][AW-1:0]        issue_dst_i,
  input  logic [ISSUE_WIDTH-1:0][TAG_WIDTH-1:0] issue_tag_i,
  input  logic [NUM_BCAST-1:0]                  bcast_valid_i,
  input  logic [NUM_BCAST-1:0][TAG_WIDTH-1:0]   bcast_tag_i,
  input  logic [NUM_BCAST-1:0][DATA_WIDTH-1:0]  bcast_value_i,
  input  logic [ISSUE_WIDTH-1:0][AW-1:0]        rd_reg1_i,
  input  logic [ISSUE_WIDTH-1:0][AW-1:0]        rd_reg2_i,
  output logic [ISSUE_WIDTH-1:0]                rd1_virtual_o,
  output logic [ISSUE_WIDTH-1:0]                rd2_virtual_o,
  output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] rd1_data_o,
  output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] rd2_data_o,
  output logic [CW-1:0]                         pending_count_o
);

  logic [NUM_REGS-1:0]                 virt_r, virt_nxt_s;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] value_r, value_nxt_s;
  logic [NUM_REGS-1:0][TAG_WIDTH-1:0]  tag_r, tag_nxt_s;
  logic [CW-1:0]                       count_r;

  // Read ports folded into one array: index 0 = operand 1, index 1 = operand 2.
  logic [1:0][ISSUE_WIDTH-1:0][AW-1:0]         rd_reg_s;
  logic [1:0][ISSUE_WIDTH-1:0]                 rd_virt_s;
  logic [1:0][ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] rd_data_s;
  logic [1:0][ISSUE_WIDTH-1:0]                 fwd_hit_s;
  logic [1:0][ISSUE_WIDTH-1:0][TAG_WIDTH-1:0]  fwd_tag_s;
  logic [1:0][ISSUE_WIDTH-1:0]                 bc_hit_s;
  logic [1:0][ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] bc_val_s;
  logic [NUM_REGS-1:0]                         issued_s;

  function automatic logic [CW-1:0] popcount(input logic [NUM_REGS-1:0] bits);
    logic [CW-1:0] sum;
    sum = {CW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sum = sum + CW'(bits[i]);
    end
    return sum;
  endfunction

  assign rd_reg_s = {rd_reg2_i, rd_reg1_i};

  // Combinational read path: r0, then intra-bundle forward, then bypass, then state.
  always_comb begin
    fwd_hit_s = '0;
    fwd_tag_s = '0;
    bc_hit_s  = '0;
    bc_val_s  = '0;
    rd_virt_s = '0;
    rd_data_s = '0;
    for (int op = 0; op < 2; op++) begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        // Ascending scan: the youngest earlier slot is written last.
        for (int i = 0; i < j; i++) begin
          fwd_tag_s[op][j] = (issue_wr_en_i[i] && issue_dst_i[i] == rd_reg_s[op][j])
                             ? issue_tag_i[i] : fwd_tag_s[op][j];
          fwd_hit_s[op][j] = fwd_hit_s[op][j]
                             | (issue_wr_en_i[i] && issue_dst_i[i] == rd_reg_s[op][j]);
        end
        // Descending scan: the lowest matching channel is written last.
        for (int c = NUM_BCAST - 1; c >= 0; c--) begin
          bc_val_s[op][j] = (bcast_valid_i[c] && bcast_tag_i[c] == tag_r[rd_reg_s[op][j]])
                            ? bcast_value_i[c] : bc_val_s[op][j];
          bc_hit_s[op][j] = bc_hit_s[op][j]
                            | (bcast_valid_i[c] && bcast_tag_i[c] == tag_r[rd_reg_s[op][j]]);
        end
        if (rd_reg_s[op][j] == {AW{1'b0}}) begin
          rd_virt_s[op][j] = 1'b0;
          rd_data_s[op][j] = {DATA_WIDTH{1'b0}};
        end else if (fwd_hit_s[op][j]) begin
          rd_virt_s[op][j] = 1'b1;
          rd_data_s[op][j] = DATA_WIDTH'(fwd_tag_s[op][j]);
        end else if (virt_r[rd_reg_s[op][j]] && bc_hit_s[op][j]) begin
          rd_virt_s[op][j] = 1'b0;
          rd_data_s[op][j] = bc_val_s[op][j];
        end else if (virt_r[rd_reg_s[op][j]]) begin
          rd_virt_s[op][j] = 1'b1;
          rd_data_s[op][j] = DATA_WIDTH'(tag_r[rd_reg_s[op][j]]);
        end else begin
          rd_virt_s[op][j] = 1'b0;
          rd_data_s[op][j] = value_r[rd_reg_s[op][j]];
        end
      end
    end
  end

  assign rd1_virtual_o = rd_virt_s[0];
  assign rd2_virtual_o = rd_virt_s[1];
  assign rd1_data_o    = rd_data_s[0];
  assign rd2_data_o    = rd_data_s[1];

  // Next-state: flush beats everything; issue beats broadcast on the same register.
  always_comb begin
    virt_nxt_s  = virt_r;
    value_nxt_s = value_r;
    tag_nxt_s   = tag_r;
    issued_s    = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      issued_s[issue_dst_i[s]] = issued_s[issue_dst_i[s]] | issue_wr_en_i[s];
    end
    if (flush_i) begin
      virt_nxt_s = '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        // Only still-virtual registers take results, so a stale tag never lands.
        for (int c = NUM_BCAST - 1; c >= 0; c--) begin
          value_nxt_s[r] = (virt_r[r] && !issued_s[r] && bcast_valid_i[c]
                            && bcast_tag_i[c] == tag_r[r]) ? bcast_value_i[c] : value_nxt_s[r];
          virt_nxt_s[r]  = (virt_r[r] && !issued_s[r] && bcast_valid_i[c]
                            && bcast_tag_i[c] == tag_r[r]) ? 1'b0 : virt_nxt_s[r];
        end
      end
      // Ascending scan so the highest slot renaming a register wins.
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        virt_nxt_s[issue_dst_i[s]] = issue_wr_en_i[s] ? 1'b1 : virt_nxt_s[issue_dst_i[s]];
        tag_nxt_s[issue_dst_i[s]]  = issue_wr_en_i[s] ? issue_tag_i[s]
                                                      : tag_nxt_s[issue_dst_i[s]];
      end
    end
    // r0 is never renamed and always reads zero.
    virt_nxt_s[0]  = 1'b0;
    value_nxt_s[0] = {DATA_WIDTH{1'b0}};
    tag_nxt_s[0]   = {TAG_WIDTH{1'b0}};
  end

  // State register and registered pending count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      virt_r  <= '0;
      value_r <= '0;
      tag_r   <= '0;
      count_r <= {CW{1'b0}};
    end else begin
      virt_r  <= virt_nxt_s;
      value_r <= value_nxt_s;
      tag_r   <= tag_nxt_s;
      count_r <= popcount(virt_nxt_s);
    end
  end

  assign pending_count_o = count_r;

endmodule

// File: tb/tb_tagged_register_file.sv
module tb_tagged_register_file;
  localparam int DW = 64, NR = 32, IW = 3, NB = 2, TW = 4;
  localparam int AW = 5, CW = 6;

  logic clk = 1'b0;
  logic rst, flush;
  logic [IW-1:0]         wr_en;
  logic [IW-1:0][AW-1:0] dst;
  logic [IW-1:0][TW-1:0] itag;
  logic [NB-1:0]         bv;
  logic [NB-1:0][TW-1:0] bt;
  logic [NB-1:0][DW-1:0] bval;
  logic [IW-1:0][AW-1:0] r1, r2;
  logic [IW-1:0]         v1, v2;
  logic [IW-1:0][DW-1:0] d1, d2;
  logic [CW-1:0]         cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic          m_virt[NR];
  logic [DW-1:0] m_val[NR];
  logic [TW-1:0] m_tag[NR];
  int            m_count;

  tagged_register_file dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .issue_wr_en_i(wr_en), .issue_dst_i(dst), .issue_tag_i(itag),
    .bcast_valid_i(bv), .bcast_tag_i(bt), .bcast_value_i(bval),
    .rd_reg1_i(r1), .rd_reg2_i(r2),
    .rd1_virtual_o(v1), .rd2_virtual_o(v2),
    .rd1_data_o(d1), .rd2_data_o(d2),
    .pending_count_o(cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) begin
      m_virt[r] = 1'b0; m_val[r] = '0; m_tag[r] = '0;
    end
    m_count = 0;
  endfunction

  // Expected read for register r seen by slot j, from the priority rules.
  function automatic void model_read(input logic [AW-1:0] r, input int j,
                                     output logic ev, output logic [DW-1:0] ed);
    if (r == 0) begin ev = 1'b0; ed = '0; return; end
    for (int i = j - 1; i >= 0; i--) begin
      if (wr_en[i] && dst[i] == r) begin ev = 1'b1; ed = DW'(itag[i]); return; end
    end
    if (m_virt[r]) begin
      for (int c = 0; c < NB; c++) begin
        if (bv[c] && bt[c] == m_tag[r]) begin ev = 1'b0; ed = bval[c]; return; end
      end
      ev = 1'b1; ed = DW'(m_tag[r]); return;
    end
    ev = 1'b0; ed = m_val[r];
  endfunction

  // Clock-edge update of the model from the current inputs.
  function automatic void model_step();
    bit issued[NR];
    for (int r = 0; r < NR; r++) issued[r] = 0;
    for (int s = 0; s < IW; s++) if (wr_en[s]) issued[dst[s]] = 1;
    if (flush) begin
      for (int r = 0; r < NR; r++) m_virt[r] = 1'b0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (m_virt[r] && !issued[r]) begin
          for (int c = 0; c < NB; c++) begin
            if (bv[c] && bt[c] == m_tag[r]) begin
              m_val[r] = bval[c]; m_virt[r] = 1'b0; break;
            end
          end
        end
      end
      for (int s = 0; s < IW; s++) begin
        if (wr_en[s] && dst[s] != 0) begin m_virt[dst[s]] = 1'b1; m_tag[dst[s]] = itag[s]; end
      end
    end
    m_count = 0;
    for (int r = 0; r < NR; r++) if (m_virt[r]) m_count++;
  endfunction

  task automatic idle();
    flush = 1'b0; wr_en = '0; dst = '0; itag = '0;
    bv = '0; bt = '0; bval = '0; r1 = '0; r2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); model_reset();
    #12; rst = 1'b0;
    r1[0] = 5'd5; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'd0 || cnt !== 6'd0) begin
      n_mis++; $display("FAIL reset_r5: got v=%0b d=%0h cnt=%0d, expected v=0 d=0 cnt=0", v1[0], d1[0], cnt);
    end
    wr_en[0] = 1'b1; dst[0] = 5'd0; itag[0] = 4'd3; r1[1] = 5'd0; #1;
    n_cmp++;
    if (v1[1] !== 1'b0 || d1[1] !== 64'd0) begin
      n_mis++; $display("FAIL r0_fwd: got v=%0b d=%0h, expected v=0 d=0", v1[1], d1[1]);
    end
    tick(); idle(); r1[0] = 5'd0; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'd0 || cnt !== 6'd0) begin
      n_mis++; $display("FAIL r0_write: got v=%0b d=%0h cnt=%0d, expected v=0 d=0 cnt=0", v1[0], d1[0], cnt);
    end
  endtask

  task automatic test_rename_bypass();
    wr_en[0] = 1'b1; dst[0] = 5'd4; itag[0] = 4'd2;
    tick(); idle(); r1[0] = 5'd4; #1;
    n_cmp++;
    if (v1[0] !== 1'b1 || d1[0] !== 64'd2 || cnt !== 6'd1) begin
      n_mis++; $display("FAIL rename_r4: got v=%0b d=%0h cnt=%0d, expected v=1 d=2 cnt=1", v1[0], d1[0], cnt);
    end
    bv[0] = 1'b1; bt[0] = 4'd2; bval[0] = 64'hDEAD; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'hDEAD) begin
      n_mis++; $display("FAIL bypass_r4: got v=%0b d=%0h, expected v=0 d=dead", v1[0], d1[0]);
    end
    tick(); idle(); r1[0] = 5'd4; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'hDEAD || cnt !== 6'd0) begin
      n_mis++; $display("FAIL stored_r4: got v=%0b d=%0h cnt=%0d, expected v=0 d=dead cnt=0", v1[0], d1[0], cnt);
    end
  endtask

  task automatic test_intra_bundle();
    wr_en[0] = 1'b1; dst[0] = 5'd7; itag[0] = 4'd1;
    wr_en[1] = 1'b1; dst[1] = 5'd7; itag[1] = 4'd5;
    r1[0] = 5'd7; r1[1] = 5'd7; r1[2] = 5'd7; #1;
    n_cmp++;
    if (v1 !== 3'b110 || d1[2] !== 64'd5 || d1[1] !== 64'd1 || d1[0] !== 64'd0) begin
      n_mis++; $display("FAIL intra_fwd: got v=%b d2=%0h d1=%0h d0=%0h, expected v=110 d2=5 d1=1 d0=0",
                        v1, d1[2], d1[1], d1[0]);
    end
    tick(); idle(); r1[0] = 5'd7; #1;
    n_cmp++;
    if (v1[0] !== 1'b1 || d1[0] !== 64'd5 || cnt !== 6'd1) begin
      n_mis++; $display("FAIL intra_state: got v=%0b d=%0h cnt=%0d, expected v=1 d=5 cnt=1", v1[0], d1[0], cnt);
    end
  endtask

  task automatic test_issue_over_bcast();
    wr_en[0] = 1'b1; dst[0] = 5'd9; itag[0] = 4'd4;
    tick(); idle();
    wr_en[0] = 1'b1; dst[0] = 5'd9; itag[0] = 4'd6;
    bv[0] = 1'b1; bt[0] = 4'd4; bval[0] = 64'h11;
    tick(); idle(); r2[1] = 5'd9; #1;
    n_cmp++;
    if (v2[1] !== 1'b1 || d2[1] !== 64'd6 || cnt !== 6'd2) begin
      n_mis++; $display("FAIL issue_wins: got v=%0b d=%0h cnt=%0d, expected v=1 d=6 cnt=2", v2[1], d2[1], cnt);
    end
    bv[1] = 1'b1; bt[1] = 4'd4; bval[1] = 64'h22; #1;
    n_cmp++;
    if (v2[1] !== 1'b1 || d2[1] !== 64'd6) begin
      n_mis++; $display("FAIL stale_bypass: got v=%0b d=%0h, expected v=1 d=6", v2[1], d2[1]);
    end
    tick(); idle(); r2[1] = 5'd9; #1;
    n_cmp++;
    if (v2[1] !== 1'b1 || d2[1] !== 64'd6 || cnt !== 6'd2) begin
      n_mis++; $display("FAIL stale_update: got v=%0b d=%0h cnt=%0d, expected v=1 d=6 cnt=2", v2[1], d2[1], cnt);
    end
  endtask

  task automatic test_dual_bcast();
    flush = 1'b1;
    tick(); idle(); r1[0] = 5'd9; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'd0 || cnt !== 6'd0) begin
      n_mis++; $display("FAIL flush_discard: got v=%0b d=%0h cnt=%0d, expected v=0 d=0 cnt=0", v1[0], d1[0], cnt);
    end
    wr_en = 3'b011; dst[0] = 5'd2; itag[0] = 4'd1; dst[1] = 5'd3; itag[1] = 4'd2;
    tick(); idle();
    n_cmp++;
    if (cnt !== 6'd2) begin
      n_mis++; $display("FAIL dual_pending: got cnt=%0d, expected cnt=2", cnt);
    end
    bv = 2'b11; bt[0] = 4'd1; bval[0] = 64'hA; bt[1] = 4'd2; bval[1] = 64'hB;
    tick(); idle(); r1[0] = 5'd2; r2[0] = 5'd3; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'hA || v2[0] !== 1'b0 || d2[0] !== 64'hB || cnt !== 6'd0) begin
      n_mis++; $display("FAIL dual_bcast: got r2=%0b/%0h r3=%0b/%0h cnt=%0d, expected 0/a 0/b cnt=0",
                        v1[0], d1[0], v2[0], d2[0], cnt);
    end
  endtask

  task automatic test_flush_and_reset();
    wr_en = 3'b111; dst[0] = 5'd11; itag[0] = 4'd1; dst[1] = 5'd12; itag[1] = 4'd2;
    dst[2] = 5'd13; itag[2] = 4'd3;
    tick(); idle();
    bv = 2'b11; bt[0] = 4'd1; bval[0] = 64'h111; bt[1] = 4'd2; bval[1] = 64'h222;
    tick(); idle();
    bv[0] = 1'b1; bt[0] = 4'd3; bval[0] = 64'h333;
    tick(); idle();
    wr_en = 3'b111; dst[0] = 5'd11; itag[0] = 4'd7; dst[1] = 5'd12; itag[1] = 4'd8;
    dst[2] = 5'd13; itag[2] = 4'd9;
    tick(); idle();
    n_cmp++;
    if (cnt !== 6'd3) begin
      n_mis++; $display("FAIL three_pending: got cnt=%0d, expected cnt=3", cnt);
    end
    flush = 1'b1; wr_en[0] = 1'b1; dst[0] = 5'd10; itag[0] = 4'd5;
    bv[0] = 1'b1; bt[0] = 4'd7; bval[0] = 64'hBAD;
    tick(); idle();
    r1[0] = 5'd11; r1[1] = 5'd12; r1[2] = 5'd13; r2[0] = 5'd10; #1;
    n_cmp++;
    if (v1 !== 3'b000 || d1[0] !== 64'h111 || d1[1] !== 64'h222 || d1[2] !== 64'h333
        || v2[0] !== 1'b0 || d2[0] !== 64'd0 || cnt !== 6'd0) begin
      n_mis++; $display("FAIL flush: got v=%b d=%0h,%0h,%0h r10=%0b/%0h cnt=%0d, expected 000 111,222,333 0/0 cnt=0",
                        v1, d1[0], d1[1], d1[2], v2[0], d2[0], cnt);
    end
    wr_en[0] = 1'b1; dst[0] = 5'd4; itag[0] = 4'd3;
    tick(); idle(); r1[0] = 5'd4; r1[1] = 5'd11;
    #3; rst = 1'b1; #1;
    n_cmp++;
    if (v1[0] !== 1'b0 || d1[0] !== 64'd0 || d1[1] !== 64'd0 || cnt !== 6'd0) begin
      n_mis++; $display("FAIL async_reset: got v=%0b d4=%0h d11=%0h cnt=%0d, expected all zero",
                        v1[0], d1[0], d1[1], cnt);
    end
    #2; rst = 1'b0; model_reset();
  endtask

  task automatic test_random();
    logic          ev;
    logic [DW-1:0] ed;
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < IW; s++) begin
        wr_en[s] = 1'($urandom_range(0, 1));
        dst[s]   = AW'($urandom_range(0, 15));
        itag[s]  = TW'($urandom);
        r1[s]    = AW'($urandom_range(0, 15));
        r2[s]    = AW'($urandom_range(0, 15));
      end
      for (int c = 0; c < NB; c++) begin
        bv[c]   = 1'($urandom_range(0, 1));
        bval[c] = {$urandom, $urandom};
      end
      bt[0] = TW'($urandom);
      bt[1] = TW'($urandom);
      while (bt[1] == bt[0]) bt[1] = TW'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      #1;
      for (int j = 0; j < IW; j++) begin
        model_read(r1[j], j, ev, ed);
        n_cmp++;
        if (v1[j] !== ev || d1[j] !== ed) begin
          n_mis++; $display("FAIL rand_rd1[%0d] cyc %0d: got v=%0b d=%0h, expected v=%0b d=%0h",
                            j, n, v1[j], d1[j], ev, ed);
        end
        model_read(r2[j], j, ev, ed);
        n_cmp++;
        if (v2[j] !== ev || d2[j] !== ed) begin
          n_mis++; $display("FAIL rand_rd2[%0d] cyc %0d: got v=%0b d=%0h, expected v=%0b d=%0h",
                            j, n, v2[j], d2[j], ev, ed);
        end
      end
      tick();
      n_cmp++;
      if (cnt !== CW'(m_count)) begin
        n_mis++; $display("FAIL rand_count cyc %0d: got %0d, expected %0d", n, cnt, m_count);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rename_bypass();
    test_intra_bundle();
    test_issue_over_bcast();
    test_dual_bcast();
    test_flush_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
